sdspi_run_ctrl: RTL and testbench
=================================

Name: sdspi_run_ctrl

Overview:
Run controller directly upstream of sdspi_system. It takes a single run request with latched UUT parameters and sequences the UUT: mux hand-over, UUT reset pulse, start strobe, and wait-for-finish with timeout. It measures the run length in clk cycles and returns the SPI pads to the autotest side when the run ends. It replaces ad-hoc sequencing of sdspi_rst, sdspi_start and sdspi_ctrl_mux inside the autotest logic.

Parameters:
RST_CYCLES, 16, clk cycles that sdspi_rst is held asserted (minimum 1)
SETTLE_CYCLES, 4, idle cycles between sdspi_rst release and sdspi_start (minimum 1)
CNT_W, 32, width of the cycle counter and of the timeout limit

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
go  in  1  run request; sampled in IDLE only
abort  in  1  forces the run to end; honoured in every non-IDLE state
n_blocks_i  in  32  block count for the run
sclk_speed_i  in  5  SPI clock divider select
cmd18_i  in  1  1 selects multi-block read (CMD18), 0 selects single-block reads
timeout_limit_i  in  CNT_W  maximum RUN cycles; 0 disables the timeout
sdspi_finish  in  1  finish level from sdspi_system
sdspi_ctrl_mux  out  1  1 routes the SD pads to the UUT, 0 to autotest
sdspi_rst  out  1  UUT reset, active-high
sdspi_start  out  1  UUT start strobe, one cycle wide
sdspi_n_blocks  out  32  parameter copy latched on go
sdspi_sclk_speed  out  5  parameter copy latched on go
sdspi_cmd18  out  1  parameter copy latched on go
busy  out  1  high in every non-IDLE state
done  out  1  one-cycle pulse at the end of a run
status_o  out  2  00 = ok, 01 = timeout, 10 = aborted; held until the next go
cycles_o  out  CNT_W  RUN length in cycles; held until the next go

Behaviour:
- Reset values: all outputs 0, and the state machine is in IDLE. Reset has priority everywhere, including mid-run; the UUT is then left with sdspi_rst=0 and the mux at 0.
- IDLE:
  - On go=1: latch n_blocks_i, sclk_speed_i, cmd18_i and timeout_limit_i; clear cycles_o and status_o; go to RESET.
  - Parameters never change outside this transition.
- RESET:
  - sdspi_ctrl_mux=1 and sdspi_rst=1 for exactly RST_CYCLES cycles, then go to SETTLE.
- SETTLE:
  - sdspi_rst=0 and sdspi_ctrl_mux=1 for SETTLE_CYCLES cycles, then go to START.
- START:
  - sdspi_start=1 for one cycle, then go to RUN. The counter is zeroed on this cycle.
- RUN:
  - The counter increments each cycle, saturating at all-ones.
  - Exit on sdspi_finish=1: status 00. cycles_o = number of RUN cycles before the one in which finish is seen. Finish in the first RUN cycle gives 0.
  - Exit on counter == latched limit (limit≠0) with finish still 0: status 01.
  - If finish and timeout occur in the same cycle, finish wins (status 00).
- DONE:
  - Lasts 1 cycle: done=1, sdspi_ctrl_mux drops to 0 this cycle, then go to IDLE.
  - busy falls on the cycle after DONE.
- Abort:
  - abort=1 in RESET, SETTLE, START or RUN forces DONE on the next edge with status 10. It overrides finish and timeout in the same cycle.
  - cycles_o holds the counter value at abort; 0 if the run was aborted before RUN.
- go while busy is ignored, and go is not queued. A go held high continuously re-triggers only when the controller returns to IDLE.
- Latency go to sdspi_start: RST_CYCLES + SETTLE_CYCLES + 1 cycles.

Optional Feature:
SDSPI_RUN_CTRL_FINISH_SYNC_EN
- Defined: sdspi_finish passes through a 2-flop synchroniser, reset to 0, before the RUN logic. Reported cycles_o is 2 larger than without the feature; it is not compensated.
- Undefined: sdspi_finish is used directly; it comes from the same clk domain.

Decomposition:
- Package sdspi_run_ctrl_pkg:
  - state encoding: IDLE, RESET, SETTLE, START, RUN, DONE (3 bits)
  - status codes: ST_OK=2'b00, ST_TIMEOUT=2'b01, ST_ABORT=2'b10
- One natural sub-module, run_cycle_counter: CNT_W-bit counter with clear, enable and saturation, plus an equality compare against the limit. It is shared between the RESET/SETTLE phase timing and the RUN measurement.

Test Plan:
1. Reset mid-RUN (rst=0 for 1 cycle) -> all outputs 0 immediately, state IDLE, sdspi_ctrl_mux=0.
2. go with n_blocks=8, sclk_speed=3, cmd18=1, limit=0; finish raised 100 cycles after start:
   - sdspi_rst high for exactly 16 cycles, start 21 cycles after go, mux=1 throughout
   - done pulse, cycles_o=100, status_o=00, mux=0 in the done cycle
3. limit=50, finish never asserted -> status_o=01, cycles_o=50, one done pulse, mux returns to 0.
4. limit=50, finish asserted exactly in the cycle where the counter reaches 50 -> status_o=00, cycles_o=50.
5. abort during SETTLE -> next cycle DONE, status_o=10, cycles_o=0, no sdspi_start pulse ever issued.
6. go pulsed during RUN with different n_blocks -> ignored; sdspi_n_blocks unchanged, no second run after DONE.

Source files
------------

// File: rtl/sdspi_run_ctrl_pkg.sv
// Shared types for the sdspi run controller: FSM state encoding and run status codes.
package sdspi_run_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RESET  = 3'd1,
        SETTLE = 3'd2,
        START  = 3'd3,
        RUN    = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_ABORT   = 2'b10;

endpackage

// File: rtl/run_cycle_counter.sv
// Saturating cycle counter with synchronous clear and an equality compare against a limit.
module run_cycle_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             at_limit
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign at_limit = (count == limit);

endmodule

// File: rtl/sdspi_run_ctrl.sv
// Run controller in front of sdspi_system: mux hand-over, UUT reset, start, timed run.
// Build option: SDSPI_RUN_CTRL_FINISH_SYNC_EN adds a 2-flop synchroniser on sdspi_finish.
module sdspi_run_ctrl
    import sdspi_run_ctrl_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             abort,
    input  logic [31:0]      n_blocks_i,
    input  logic [4:0]       sclk_speed_i,
    input  logic             cmd18_i,
    input  logic [CNT_W-1:0] timeout_limit_i,
    input  logic             sdspi_finish,
    output logic             sdspi_ctrl_mux,
    output logic             sdspi_rst,
    output logic             sdspi_start,
    output logic [31:0]      sdspi_n_blocks,
    output logic [4:0]       sdspi_sclk_speed,
    output logic             sdspi_cmd18,
    output logic             busy,
    output logic             done,
    output logic [1:0]       status_o,
    output logic [CNT_W-1:0] cycles_o,
    output logic [2:0]       dbg_state
);

    // Control semantics: go is a level request with no ready; it is only looked at
    // in IDLE (busy=0), is never queued, and a held go starts a new run on every
    // return to IDLE. abort is a level sampled in every active phase. sdspi_finish
    // is a level; the first RUN cycle in which it is seen ends the run.

    localparam logic [CNT_W-1:0] RST_LIM    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LIM = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] limit_q;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] cmp_limit;
    logic             at_limit;
    logic             cnt_clr;
    logic             cnt_en;
    logic             latch_go;
    logic             end_run;
    logic [1:0]       end_status;
    logic             finish_run;

`ifdef SDSPI_RUN_CTRL_FINISH_SYNC_EN
    logic [1:0] finish_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            finish_sync <= '0;
        end else begin
            finish_sync <= {finish_sync[0], sdspi_finish};
        end
    end

    assign finish_run = finish_sync[1];
`else
    assign finish_run = sdspi_finish;
`endif

    // One counter times the RESET and SETTLE phases and then measures RUN;
    // the compare limit is switched per phase.
    run_cycle_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .limit   (cmp_limit),
        .count   (count),
        .at_limit(at_limit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        cnt_en     = 1'b0;
        cmp_limit  = '0;
        latch_go   = 1'b0;
        end_run    = 1'b0;
        end_status = ST_OK;
        case (state)
            IDLE: begin
                if (go) begin
                    next_state = RESET;
                    latch_go   = 1'b1;
                end
            end
            RESET: begin
                cnt_en    = 1'b1;
                cmp_limit = RST_LIM;
                if (abort) begin
                    next_state = DONE;
                    end_run    = 1'b1;
                    end_status = ST_ABORT;
                end else if (at_limit) begin
                    next_state = SETTLE;
                end
            end
            SETTLE: begin
                cnt_en    = 1'b1;
                cmp_limit = SETTLE_LIM;
                if (abort) begin
                    next_state = DONE;
                    end_run    = 1'b1;
                    end_status = ST_ABORT;
                end else if (at_limit) begin
                    next_state = START;
                end
            end
            START: begin
                if (abort) begin
                    next_state = DONE;
                    end_run    = 1'b1;
                    end_status = ST_ABORT;
                end else begin
                    next_state = RUN;
                end
            end
            RUN: begin
                cnt_en    = 1'b1;
                cmp_limit = limit_q;
                if (abort) begin
                    next_state = DONE;
                    end_run    = 1'b1;
                    end_status = ST_ABORT;
                end else if (finish_run) begin
                    next_state = DONE;
                    end_run    = 1'b1;
                    end_status = ST_OK;
                end else if (at_limit && (limit_q != '0)) begin
                    next_state = DONE;
                    end_run    = 1'b1;
                    end_status = ST_TIMEOUT;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Every phase change restarts the counter, so START leaves it at 0 for RUN.
    assign cnt_clr = (next_state != state);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sdspi_n_blocks   <= '0;
            sdspi_sclk_speed <= '0;
            sdspi_cmd18      <= 1'b0;
            limit_q          <= '0;
            status_o         <= ST_OK;
            cycles_o         <= '0;
        end else begin
            if (latch_go) begin
                sdspi_n_blocks   <= n_blocks_i;
                sdspi_sclk_speed <= sclk_speed_i;
                sdspi_cmd18      <= cmd18_i;
                limit_q          <= timeout_limit_i;
                status_o         <= ST_OK;
                cycles_o         <= '0;
            end
            if (end_run) begin
                status_o <= end_status;
                cycles_o <= (state == RUN) ? count : '0;
            end
        end
    end

    assign sdspi_ctrl_mux = (state == RESET) || (state == SETTLE) ||
                            (state == START) || (state == RUN);
    assign sdspi_rst      = (state == RESET);
    assign sdspi_start    = (state == START);
    assign busy           = (state != IDLE);
    assign done           = (state == DONE);
    assign dbg_state      = state;

endmodule

// File: tb/tb_sdspi_run_ctrl.sv
// Self-checking bench for sdspi_run_ctrl: vector table of runs plus hand-written corner sequences.
module tb_sdspi_run_ctrl;
    import sdspi_run_ctrl_pkg::*;

    localparam int CNT_W      = 32;
    localparam int EXP_W      = CNT_W + 2;
    localparam int RUN_BUDGET = 400;
    localparam int START_CYC  = 21;
    localparam int FIN_BASE   = 22;
    localparam int N_VEC      = 12;
`ifdef SDSPI_RUN_CTRL_FINISH_SYNC_EN
    localparam int SYNC_D = 2;
`else
    localparam int SYNC_D = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             go;
    logic             abort;
    logic [31:0]      n_blocks_i;
    logic [4:0]       sclk_speed_i;
    logic             cmd18_i;
    logic [CNT_W-1:0] timeout_limit_i;
    logic             sdspi_finish;
    logic             sdspi_ctrl_mux;
    logic             sdspi_rst;
    logic             sdspi_start;
    logic [31:0]      sdspi_n_blocks;
    logic [4:0]       sdspi_sclk_speed;
    logic             sdspi_cmd18;
    logic             busy;
    logic             done;
    logic [1:0]       status_o;
    logic [CNT_W-1:0] cycles_o;
    logic [2:0]       dbg_state;

    sdspi_run_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .go              (go),
        .abort           (abort),
        .n_blocks_i      (n_blocks_i),
        .sclk_speed_i    (sclk_speed_i),
        .cmd18_i         (cmd18_i),
        .timeout_limit_i (timeout_limit_i),
        .sdspi_finish    (sdspi_finish),
        .sdspi_ctrl_mux  (sdspi_ctrl_mux),
        .sdspi_rst       (sdspi_rst),
        .sdspi_start     (sdspi_start),
        .sdspi_n_blocks  (sdspi_n_blocks),
        .sdspi_sclk_speed(sdspi_sclk_speed),
        .sdspi_cmd18     (sdspi_cmd18),
        .busy            (busy),
        .done            (done),
        .status_o        (status_o),
        .cycles_o        (cycles_o),
        .dbg_state       (dbg_state)
    );

    // Clock/reset
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [EXP_W-1:0] exp_q[$];

    typedef struct {
        logic [31:0]      n_blocks;
        logic [4:0]       sclk;
        logic             cmd18;
        logic [CNT_W-1:0] limit;
        int               fin_run;   // RUN count at which finish is seen, -1 = never
        int               abort_at;  // cycle index (go cycle = 0) of abort, -1 = never
        int               go2_at;    // cycle index of a stray go, -1 = none
        logic [1:0]       exp_status;
        logic [CNT_W-1:0] exp_cycles;
    } vec_t;

    vec_t vecs[N_VEC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        go              = 1'b0;
        abort           = 1'b0;
        sdspi_finish    = 1'b0;
        n_blocks_i      = '0;
        sclk_speed_i    = '0;
        cmd18_i         = 1'b0;
        timeout_limit_i = '0;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctl"}, 64'({sdspi_ctrl_mux, sdspi_rst, sdspi_start, busy, done}), 64'd0);
        check({name, "_res"}, 64'({status_o, cycles_o}), 64'd0);
        check({name, "_par"}, 64'({sdspi_n_blocks, sdspi_sclk_speed, sdspi_cmd18}), 64'd0);
        check({name, "_state"}, 64'(dbg_state), 64'(IDLE));
    endtask

    // Driver + monitor for one table entry; the scoreboard entry is pushed as go is driven.
    task automatic run_vec(input int idx, input vec_t v);
        int rst_hi = 0;
        int start_cnt = 0;
        int start_at = -1;
        int done_at = -1;
        int mux_bad = 0;
        int late_busy = 0;
        int exp_rst_hi;
        int exp_starts;
        int exp_done_at;
        bit got_done = 1'b0;
        logic [EXP_W-1:0] e;
        string tag;
        tag = $sformatf("v%0d", idx);
        exp_q.push_back({v.exp_status, v.exp_cycles});
        for (int cyc = 0; cyc < RUN_BUDGET && !got_done; cyc++) begin
            @(negedge clk);
            if (sdspi_rst) rst_hi++;
            if (sdspi_start) begin
                start_cnt++;
                start_at = cyc;
            end
            if (busy && !done && !sdspi_ctrl_mux) mux_bad++;
            if (done) begin
                got_done = 1'b1;
                done_at  = cyc;
                check({tag, "_done_mux"}, 64'(sdspi_ctrl_mux), 64'd0);
                if (exp_q.size() == 0) begin
                    check({tag, "_sb_empty"}, 64'd0, 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check({tag, "_status"}, 64'(status_o), 64'(e[EXP_W-1 -: 2]));
                    check({tag, "_cycles"}, 64'(cycles_o), 64'(e[CNT_W-1:0]));
                end
                check({tag, "_params"}, 64'({sdspi_n_blocks, sdspi_sclk_speed, sdspi_cmd18}),
                      64'({v.n_blocks, v.sclk, v.cmd18}));
            end
            if (got_done) begin
                idle_inputs();
            end else begin
                go           = (cyc == 0) || (cyc == v.go2_at);
                abort        = (cyc == v.abort_at);
                sdspi_finish = (v.fin_run >= 0) && (cyc >= FIN_BASE + v.fin_run - SYNC_D);
                if (cyc == 0) begin
                    n_blocks_i      = v.n_blocks;
                    sclk_speed_i    = v.sclk;
                    cmd18_i         = v.cmd18;
                    timeout_limit_i = v.limit;
                end else begin
                    n_blocks_i      = $urandom;
                    sclk_speed_i    = 5'($urandom_range(31));
                    cmd18_i         = 1'($urandom_range(1));
                    timeout_limit_i = CNT_W'($urandom_range(1, 20));
                end
            end
        end
        check({tag, "_got_done"}, 64'(got_done), 64'd1);
        exp_rst_hi  = (v.abort_at >= 1 && v.abort_at <= 16) ? v.abort_at : 16;
        exp_starts  = (v.abort_at < 0 || v.abort_at >= START_CYC) ? 1 : 0;
        exp_done_at = (v.abort_at >= 0) ? v.abort_at + 1 : FIN_BASE + 1 + int'(v.exp_cycles);
        check({tag, "_rst_cycles"}, 64'(rst_hi), 64'(exp_rst_hi));
        check({tag, "_starts"}, 64'(start_cnt), 64'(exp_starts));
        if (exp_starts == 1) check({tag, "_start_at"}, 64'(start_at), 64'(START_CYC));
        check({tag, "_done_at"}, 64'(done_at), 64'(exp_done_at));
        check({tag, "_mux_hold"}, 64'(mux_bad), 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (busy || done) late_busy++;
        end
        check({tag, "_no_rerun"}, 64'(late_busy), 64'd0);
    endtask

    initial begin
        vecs[0]  = '{32'd8,  5'd3, 1'b1, 32'd0,  100, -1, -1, ST_OK,      32'd100};
        vecs[1]  = '{32'd1,  5'd0, 1'b0, 32'd50, -1,  -1, -1, ST_TIMEOUT, 32'd50};
        vecs[2]  = '{32'd5,  5'd7, 1'b1, 32'd50, 50,  -1, -1, ST_OK,      32'd50};
        vecs[3]  = '{32'd12, 5'd2, 1'b0, 32'd0,  -1,  18, -1, ST_ABORT,   32'd0};
        vecs[4]  = '{32'd3,  5'd1, 1'b1, 32'd0,  -1,  5,  -1, ST_ABORT,   32'd0};
        vecs[5]  = '{32'd9,  5'd4, 1'b0, 32'd0,  -1,  52, -1, ST_ABORT,   32'd30};
        vecs[6]  = '{32'd6,  5'd5, 1'b1, 32'd0,  -1,  21, -1, ST_ABORT,   32'd0};
        vecs[7]  = '{32'd7,  5'd6, 1'b0, 32'd0,  10,  32, -1, ST_ABORT,   32'd10};
        vecs[8]  = '{32'd2,  5'd8, 1'b1, 32'd0,  0,   -1, -1, ST_OK,      32'd0};
        vecs[9]  = '{32'd4,  5'd9, 1'b0, 32'd1,  -1,  -1, -1, ST_TIMEOUT, 32'd1};
        vecs[10] = '{32'd8,  5'd3, 1'b1, 32'd60, 20,  -1, 30, ST_OK,      32'd20};
        vecs[11].n_blocks   = $urandom;
        vecs[11].sclk       = 5'($urandom_range(31));
        vecs[11].cmd18      = 1'($urandom_range(1));
        vecs[11].limit      = CNT_W'($urandom_range(40, 60));
        vecs[11].fin_run    = int'($urandom_range(2, 35));
        vecs[11].abort_at   = -1;
        vecs[11].go2_at     = -1;
        vecs[11].exp_status = ST_OK;
        vecs[11].exp_cycles = CNT_W'(vecs[11].fin_run);

        idle_inputs();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < N_VEC; i++) run_vec(i, vecs[i]);

        // Reset in the middle of a run clears everything at once.
        go = 1'b1;
        n_blocks_i = 32'd77;
        sclk_speed_i = 5'd11;
        cmd18_i = 1'b1;
        @(negedge clk);
        idle_inputs();
        repeat (30) @(negedge clk);
        check("midrst_in_run", 64'({busy, dbg_state}), 64'({1'b1, RUN}));
        rst = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // A held go starts a fresh run right after returning to IDLE.
        begin
            bit seen = 1'b0;
            go = 1'b1;
            timeout_limit_i = CNT_W'(5);
            for (int c = 0; c < RUN_BUDGET && !seen; c++) begin
                @(negedge clk);
                if (done) seen = 1'b1;
            end
            check("hold_done_seen", 64'(seen), 64'd1);
            check("hold_timeout", 64'({status_o, cycles_o}), 64'({ST_TIMEOUT, 32'd5}));
            @(negedge clk);
            check("hold_idle_gap", 64'({busy, dbg_state}), 64'({1'b0, IDLE}));
            @(negedge clk);
            check("hold_rerun", 64'({busy, sdspi_rst, dbg_state}), 64'({1'b1, 1'b1, RESET}));
            go = 1'b0;
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            check("hold_abort_done", 64'({done, status_o, cycles_o}), 64'({1'b1, ST_ABORT, 32'd0}));
            @(negedge clk);
            idle_inputs();
        end

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
